// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - time-division demultiplexer recovering N channels from a sync-framed shared line
module tdm_demux #(
  parameter int N = 2,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [W-1:0]   z,
  input  logic           sync,
  output logic [N*W-1:0] y,
  output logic           valid,
  output logic [SW-1:0]  s,
  output logic           locked,
  output logic           sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [(N-1)*W-1:0]   shadow_q, shadow_d;
  logic [N*W-1:0]       y_q, y_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 sync_err_q, sync_err_d;

  // Next-state: framing FSM, slot routing into shadow, frame publish on last slot
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    shadow_d   = shadow_q;
    y_d        = y_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    locked_d   = locked_q;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[W-1:0] = z;
            s_d             = SW'(1);
            state_d         = RUN;
            locked_d        = 1'b1;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync away from slot 0 abandons the partial frame and restarts at slot 0
            sync_err_d      = (s_q != '0);
            shadow_d[W-1:0] = z;
            s_d             = SW'(1);
          end else if (s_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            locked_d   = 1'b0;
            s_d        = '0;
          end else if (s_q == LAST) begin
            // Last sample goes straight into y so the frame is complete on this edge
            y_d     = {z, shadow_q};
            valid_d = 1'b1;
            s_d     = '0;
          end else begin
            for (int k = 1; k < N - 1; k++) begin
              if (s_q == SW'(k)) begin
                shadow_d[k*W +: W] = z;
              end
            end
            s_d = s_q + SW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      s_q        <= '0;
      shadow_q   <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      shadow_q   <= shadow_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign y        = y_q;
  assign valid    = valid_q;
  assign s        = s_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux with queue-based frame model
module tb_tdm_demux;

  localparam int N  = 2;
  localparam int W  = 1;
  localparam int SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           sync = 1'b0;
  logic [W-1:0]   z = '0;
  logic [N*W-1:0] y;
  logic           valid;
  logic [SW-1:0]  s;
  logic           locked;
  logic           sync_err;

  tdm_demux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .z(z), .sync(sync),
    .y(y), .valid(valid), .s(s), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] y;
    logic           v;
    logic [SW-1:0]  s;
    logic           lk;
    logic           se;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Reference model: hunting flag, samples of the frame in progress, last published frame
  bit             hunting = 1'b1;
  logic [W-1:0]   fb[$];
  logic [N*W-1:0] y_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_en(input logic sy, input logic [W-1:0] zz, output logic v, output logic se);
    v = 1'b0;
    se = 1'b0;
    if (hunting) begin
      if (sy) begin
        fb.delete();
        fb.push_back(zz);
        hunting = 1'b0;
      end
    end else if (sy) begin
      se = (fb.size() != 0);
      fb.delete();
      fb.push_back(zz);
    end else if (fb.size() == 0) begin
      se = 1'b1;
      hunting = 1'b1;
    end else begin
      fb.push_back(zz);
      if (fb.size() == N) begin
        for (int k = 0; k < N; k++) y_m[k*W +: W] = fb[k];
        v = 1'b1;
        fb.delete();
      end
    end
  endtask

  task automatic push_exp(input logic v, input logic se);
    exp_t e;
    e.y  = y_m;
    e.v  = v;
    e.s  = hunting ? '0 : SW'(fb.size());
    e.lk = !hunting;
    e.se = se;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic cyc(input logic e, input logic sy, input logic [W-1:0] zz);
    logic v, se;
    en = e;
    sync = sy;
    z = zz;
    @(posedge clk);
    #1;
    v = 1'b0;
    se = 1'b0;
    if (e) model_en(sy, zz, v, se);
    push_exp(v, se);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    #1;
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("rst_y", 64'(y), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_s", 64'(s), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_sync_err", 64'(sync_err), 64'h0);
    hunting = 1'b1;
    fb.delete();
    y_m = '0;
    @(posedge clk);
    #1;
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every negedge, pop the expectation for the preceding edge and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) valid_cnt++;
      if (sync_err === 1'b1) err_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("y", 64'(y), 64'(e.y));
        chk("valid", 64'(valid), 64'(e.v));
        chk("s", 64'(s), 64'(e.s));
        chk("locked", 64'(locked), 64'(e.lk));
        chk("sync_err", 64'(sync_err), 64'(e.se));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    logic e, sy;
    rst = 1'b1;
    @(negedge clk);
    rst_pulse();

    // Reset mid-frame, then a clean frame
    cyc(1, 1, 1);
    rst_pulse();
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    #1 chk("t1_y", 64'(y), 64'h1);

    // Continuous frames
    v0 = valid_cnt;
    repeat (4) begin
      cyc(1, 1, 1);
      cyc(1, 0, 0);
    end
    #1;
    chk("t2_valids", 64'(valid_cnt - v0), 64'd4);
    chk("t2_y", 64'(y), 64'h1);
    chk("t2_locked", 64'(locked), 64'h1);

    // en toggling stretches frames
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (3) begin
      cyc(1, 1, 1);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    #1;
    chk("t3_valids", 64'(valid_cnt - v0), 64'd3);
    chk("t3_errs", 64'(err_cnt - e0), 64'd0);
    chk("t3_y", 64'(y), 64'h1);

    // Start on a non-sync sample
    rst_pulse();
    v0 = valid_cnt;
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    #1;
    chk("t4_y", 64'(y), 64'h2);
    chk("t4_valids", 64'(valid_cnt - v0), 64'd1);

    // Early sync
    rst_pulse();
    v0 = valid_cnt;
    e0 = err_cnt;
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    #1;
    chk("t5_y", 64'(y), 64'h2);
    chk("t5_errs", 64'(err_cnt - e0), 64'd1);
    chk("t5_valids", 64'(valid_cnt - v0), 64'd1);

    // Missing sync
    rst_pulse();
    e0 = err_cnt;
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    #1;
    chk("t6_y", 64'(y), 64'h3);
    chk("t6_errs", 64'(err_cnt - e0), 64'd1);
    chk("t6_locked", 64'(locked), 64'h0);

    // Randomized stream with occasional framing faults and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 300 == 0) begin
        rst_pulse();
      end else begin
        e = ($urandom % 4) != 0;
        if (hunting) sy = ($urandom % 3) == 0;
        else sy = (fb.size() == 0);
        if ($urandom % 16 == 0) sy = ~sy;
        cyc(e, sy, W'($urandom));
      end
    end

    en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
